spdif_decoder: RTL
==================

SPDIF_DECODER -- requirements
Module: spdif_decoder

Interface
REQ-001 Parameter MIN_IVL, default 4: intervals shorter than this many Clk cycles are glitches.
REQ-002 Parameter THR_12, default 12: intervals shorter than this are 1 half-cell (UI).
REQ-003 Parameter THR_23, default 20: intervals shorter than this are 2 UI; intervals from THR_23 up to TIMEOUT-1 are 3 UI.
REQ-004 Parameter TIMEOUT, default 32: an interval of this many cycles is loss of signal.
REQ-005 nReset  input  1  asynchronous, active-low reset.
REQ-006 Clk  input  1  sample clock, nominally 8 cycles per UI.
REQ-007 SPDIF  input  1  biphase-mark serial stream, asynchronous to Clk.
REQ-008 Audio  output  24  subframe bits 4..27; bit 4 is the LSB.
REQ-009 V, U, C  output  1 each  subframe bits 28, 29, 30.
REQ-010 Preamble  output  2  0=B, 1=M, 2=W.
REQ-011 Parity_Error  output  1  high when bits 4..31 have odd parity.
REQ-012 Strobe  output  1  one-cycle pulse; Audio, V, U, C, Preamble and Parity_Error are valid and held until the next Strobe.
REQ-013 Code_Error  output  1  one-cycle pulse on any coding violation.
REQ-014 Locked  output  1  decoder is tracking valid subframes.

Function
REQ-015 SPDIF shall pass through a 2-flop synchronizer, then an edge detector comparing the synchronized value with its previous value (input-to-edge latency 3 cycles).
REQ-016 An interval counter shall count cycles since the last edge, reset to 1 on each edge, and saturate at TIMEOUT.
REQ-017 Each edge shall classify the counter value as GLITCH (<MIN_IVL), I1, I2 or I3 per REQ-001..003.
REQ-018 FSM states: HUNT, PRE, DATA; reset state HUNT.
REQ-019 HUNT: an I3 enters PRE with run count 1; any other class stays in HUNT and raises no Code_Error.
REQ-020 PRE: collect 3 further intervals. 3-1-1-3 gives B, 3-3-1-1 gives M, 3-2-1-2 gives W; the next state is DATA with bit index 4 and half-pending cleared.
REQ-021 PRE: any other sequence shall pulse Code_Error and return to HUNT. If the offending interval is I3, it enters PRE with run count 1 instead.
REQ-022 DATA, I2 with half-pending clear: shift in 0.
REQ-023 DATA, I1: set half-pending if it is clear; otherwise shift in 1 and clear half-pending.
REQ-024 DATA, I2 with half-pending set, or GLITCH: pulse Code_Error and go to HUNT.
REQ-025 DATA, I3: pulse Code_Error and enter PRE with run count 1.
REQ-026 When bit 31 has been shifted in (28 data bits), the block shall register the outputs and pulse Strobe the following cycle, then re-enter PRE awaiting an I3.
REQ-027 Parity_Error shall be the XOR of bits 4..31.
REQ-028 Locked shall rise on the second consecutive Strobe with no intervening Code_Error.
REQ-029 Locked shall fall on Code_Error, or in the cycle the interval counter reaches TIMEOUT.
REQ-030 Reaching TIMEOUT shall force HUNT without a Code_Error pulse.
REQ-031 Parity_Error does not affect Locked.
REQ-032 Code_Error and Strobe in the same cycle is impossible by construction; if both arise, Code_Error wins and Strobe is suppressed.

Reset
REQ-033 Asserting nReset shall immediately set: FSM to HUNT, synchronizer flops 0, counter 1, shift register 0, Audio 0, V/U/C 0, Preamble 0, Parity_Error 0, Strobe 0, Code_Error 0, Locked 0.
REQ-034 Reset asserted mid-subframe shall discard the partial subframe; no Strobe follows deassertion until a complete preamble and 28 bits are received.
REQ-035 Outputs shall reach reset values with no Clk edge required.

Verification
REQ-036 B-preamble subframe, Audio=0x123456, V=0 U=1 C=0, correct parity, at 8 cycles/UI -> one Strobe; Audio=0x123456, Preamble=0, U=1, Parity_Error=0.
REQ-037 Alternating M and W subframes, 4 frames -> Locked high at the 2nd Strobe; Preamble sequence 1,2,1,2.
REQ-038 Bit 31 inverted -> Strobe with Parity_Error=1; Locked stays high.
REQ-039 Single 2-cycle glitch mid-DATA -> Code_Error pulse, Locked low, no Strobe for that subframe; the next valid subframe Strobes normally.
REQ-040 SPDIF held constant for 40 cycles -> Locked falls at counter=32; FSM in HUNT; no Code_Error.
REQ-041 nReset pulsed at data bit 15 -> all outputs 0 immediately; the first Strobe appears only after the next full subframe.

Source files
------------

// File: rtl/spdif_decoder.sv
// S/PDIF biphase-mark subframe decoder: synchronises the line, measures edge
// intervals in half-cell units, tracks preambles and shifts out 28-bit subframes.
module spdif_decoder #(
  parameter int MIN_IVL = 4,
  parameter int THR_12  = 12,
  parameter int THR_23  = 20,
  parameter int TIMEOUT = 32
) (
  input  logic        nReset,
  input  logic        Clk,
  input  logic        SPDIF,
  output logic [23:0] Audio,
  output logic        V,
  output logic        U,
  output logic        C,
  output logic [1:0]  Preamble,
  output logic        Parity_Error,
  output logic        Strobe,
  output logic        Code_Error,
  output logic        Locked
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_HUNT = 2'd0, S_PRE = 2'd1, S_DATA = 2'd2} state_t;
  typedef enum logic [2:0] {C_GL = 3'd0, C_I1 = 3'd1, C_I2 = 3'd2, C_I3 = 3'd3, C_LOS = 3'd4} cls_t;

  function automatic logic parity28(input logic [27:0] d);
    return ^d;
  endfunction

  logic          r_sync1, r_sync2, r_prev;
  logic [CW-1:0] r_cnt;
  state_t        r_state, w_state_nx;
  logic [1:0]    r_run, w_run_nx;
  cls_t          r_second, w_second_nx, w_cls, w_expect;
  logic [1:0]    r_pre, w_pre_nx, w_pre_code;
  logic [4:0]    r_idx, w_idx_nx;
  logic          r_half, w_half_nx;
  logic [27:0]   r_shift, w_shift_nx;
  logic          w_cerr, w_done, w_bit_ok, w_bit;
  logic          r_done, r_good;
  logic [23:0]   r_audio;
  logic          r_v, r_u, r_c, r_perr, r_strobe, r_code_err, r_locked;
  logic [1:0]    r_pre_out;
  logic          w_edge, w_timeout, w_strobe_ok;

  assign w_edge      = r_sync2 ^ r_prev;
  assign w_timeout   = !w_edge && (r_cnt == CW'(TIMEOUT - 1));
  assign w_strobe_ok = r_done && !w_cerr;

  // Line synchroniser, edge history and saturating interval counter.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_cnt   <= CW'(1);
    end else begin
      r_sync1 <= SPDIF;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (w_edge)
        r_cnt <= CW'(1);
      else if (r_cnt != CW'(TIMEOUT))
        r_cnt <= r_cnt + CW'(1);
    end
  end

  // Interval classification and the preamble pattern implied by the second interval.
  always_comb begin
    w_cls      = C_I3;
    w_expect   = C_I2;
    w_pre_code = 2'd2;
    if (r_cnt >= CW'(TIMEOUT))      w_cls = C_LOS;
    else if (r_cnt < CW'(MIN_IVL))  w_cls = C_GL;
    else if (r_cnt < CW'(THR_12))   w_cls = C_I1;
    else if (r_cnt < CW'(THR_23))   w_cls = C_I2;
    else                            w_cls = C_I3;
    case (r_second)
      C_I1:    begin w_expect = C_I3; w_pre_code = 2'd0; end
      C_I3:    begin w_expect = C_I1; w_pre_code = 2'd1; end
      default: begin w_expect = C_I2; w_pre_code = 2'd2; end
    endcase
  end

  // Decoder next-state: preamble tracking, biphase bit recovery, coding violations.
  always_comb begin
    w_state_nx  = r_state;
    w_run_nx    = r_run;
    w_second_nx = r_second;
    w_pre_nx    = r_pre;
    w_idx_nx    = r_idx;
    w_half_nx   = r_half;
    w_shift_nx  = r_shift;
    w_cerr      = 1'b0;
    w_done      = 1'b0;
    w_bit_ok    = 1'b0;
    w_bit       = 1'b0;
    if (w_timeout) begin
      w_state_nx = S_HUNT;
    end else if (w_edge) begin
      case (r_state)
        S_HUNT: begin
          if (w_cls == C_I3) begin w_state_nx = S_PRE; w_run_nx = 2'd1; end
          else               w_state_nx = S_HUNT;
        end
        S_PRE: begin
          case (r_run)
            2'd0: begin
              if (w_cls == C_I3) w_run_nx = 2'd1;
              else begin w_cerr = 1'b1; w_state_nx = S_HUNT; end
            end
            2'd1: begin
              if (w_cls == C_I1 || w_cls == C_I2 || w_cls == C_I3) begin
                w_second_nx = w_cls;
                w_run_nx    = 2'd2;
              end else begin
                w_cerr = 1'b1; w_state_nx = S_HUNT;
              end
            end
            2'd2: begin
              if (w_cls == C_I1)      w_run_nx = 2'd3;
              else if (w_cls == C_I3) begin w_cerr = 1'b1; w_run_nx = 2'd1; end
              else                    begin w_cerr = 1'b1; w_state_nx = S_HUNT; end
            end
            default: begin
              if (w_cls == w_expect) begin
                w_state_nx = S_DATA;
                w_idx_nx   = 5'd4;
                w_half_nx  = 1'b0;
                w_pre_nx   = w_pre_code;
              end else if (w_cls == C_I3) begin
                w_cerr = 1'b1; w_run_nx = 2'd1;
              end else begin
                w_cerr = 1'b1; w_state_nx = S_HUNT;
              end
            end
          endcase
        end
        S_DATA: begin
          case (w_cls)
            C_I1: begin
              if (!r_half) w_half_nx = 1'b1;
              else begin w_half_nx = 1'b0; w_bit_ok = 1'b1; w_bit = 1'b1; end
            end
            C_I2: begin
              if (!r_half) begin w_bit_ok = 1'b1; w_bit = 1'b0; end
              else         begin w_cerr = 1'b1; w_state_nx = S_HUNT; end
            end
            C_I3:    begin w_cerr = 1'b1; w_state_nx = S_PRE; w_run_nx = 2'd1; end
            default: begin w_cerr = 1'b1; w_state_nx = S_HUNT; end
          endcase
        end
        default: w_state_nx = S_HUNT;
      endcase
    end else begin
      w_state_nx = r_state;
    end
    // Bits arrive LSB first; the last one closes the subframe and re-arms the preamble search.
    if (w_bit_ok) begin
      w_shift_nx = {w_bit, r_shift[27:1]};
      if (r_idx == 5'd31) begin
        w_done     = 1'b1;
        w_state_nx = S_PRE;
        w_run_nx   = 2'd0;
      end else begin
        w_idx_nx = r_idx + 5'd1;
      end
    end else begin
      w_shift_nx = r_shift;
    end
  end

  // Decoder state registers.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_state  <= S_HUNT;
      r_run    <= 2'd0;
      r_second <= C_I1;
      r_pre    <= 2'd0;
      r_idx    <= 5'd4;
      r_half   <= 1'b0;
      r_shift  <= 28'd0;
    end else begin
      r_state  <= w_state_nx;
      r_run    <= w_run_nx;
      r_second <= w_second_nx;
      r_pre    <= w_pre_nx;
      r_idx    <= w_idx_nx;
      r_half   <= w_half_nx;
      r_shift  <= w_shift_nx;
    end
  end

  // Output capture, strobe/error pulses and lock tracking.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_done     <= 1'b0;
      r_strobe   <= 1'b0;
      r_code_err <= 1'b0;
      r_audio    <= 24'd0;
      r_v        <= 1'b0;
      r_u        <= 1'b0;
      r_c        <= 1'b0;
      r_pre_out  <= 2'd0;
      r_perr     <= 1'b0;
      r_good     <= 1'b0;
      r_locked   <= 1'b0;
    end else begin
      r_done     <= w_done;
      r_strobe   <= w_strobe_ok;
      r_code_err <= w_cerr;
      if (w_strobe_ok) begin
        r_audio   <= r_shift[23:0];
        r_v       <= r_shift[24];
        r_u       <= r_shift[25];
        r_c       <= r_shift[26];
        r_pre_out <= r_pre;
        r_perr    <= parity28(r_shift);
      end
      if (w_cerr || w_timeout) begin
        r_good   <= 1'b0;
        r_locked <= 1'b0;
      end else if (w_strobe_ok) begin
        r_good <= 1'b1;
        if (r_good) r_locked <= 1'b1;
      end
    end
  end

  assign Audio        = r_audio;
  assign V            = r_v;
  assign U            = r_u;
  assign C            = r_c;
  assign Preamble     = r_pre_out;
  assign Parity_Error = r_perr;
  assign Strobe       = r_strobe;
  assign Code_Error   = r_code_err;
  assign Locked       = r_locked;

endmodule
